// File: rtl/pipe_mem_pkg.sv
// Shared limits for the pipe_mem delay line.
// Legal ranges for depth and width, checked at elaboration.
package pipe_mem_pkg;

    localparam int H_MIN = 1;
    localparam int H_MAX = 64;
    localparam int W_MIN = 1;
    localparam int W_MAX = 1024;

    function automatic bit cfg_legal(input int h, input int w);
        return (h >= H_MIN) && (h <= H_MAX) &&
               (w >= W_MIN) && (w <= W_MAX);
    endfunction

endpackage

// File: rtl/pipe_mem_stage.sv
// One W-bit register of the delay line.
// Cleared asynchronously while reset is low.
module pipe_mem_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_mem.sv
// Fixed-latency delay line: H chained registers, no flow control.
// Output equals the input captured H rising edges earlier.
module pipe_mem #(
    parameter int H = 5,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    import pipe_mem_pkg::*;

    if (!cfg_legal(H, W)) begin : g_bad_cfg
        $error("pipe_mem: H or W out of legal range");
    end

    // s[k] feeds stage k; s[H] is the last stage output.
    logic [W-1:0] s [0:H];

    assign s[0] = in;

    for (genvar k = 0; k < H; k++) begin : g_stage
        pipe_mem_stage #(
            .W(W)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .d    (s[k]),
            .q    (s[k+1])
        );
    end

    assign out = s[H];

endmodule

// File: tb/tb_pipe_mem.sv
// Scoreboard bench for pipe_mem at H=5/W=32, H=1/W=1 and H=64/W=128.
// Expected words are queued at drive time and popped after each edge.
module tb_pipe_mem;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  in5 = '0;
    logic [31:0]  out5;
    logic         in1 = 1'b0;
    logic         out1;
    logic [127:0] in64 = '0;
    logic [127:0] out64;

    int total = 0;
    int bad = 0;

    logic [31:0]  q5  [$];
    logic         q1  [$];
    logic [127:0] q64 [$];

    always #10 clk = ~clk;

    pipe_mem #(.H(5), .W(32)) u_dut5 (
        .clk  (clk),
        .reset(reset),
        .in   (in5),
        .out  (out5)
    );

    pipe_mem #(.H(1), .W(1)) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .in   (in1),
        .out  (out1)
    );

    pipe_mem #(.H(64), .W(128)) u_dut64 (
        .clk  (clk),
        .reset(reset),
        .in   (in64),
        .out  (out64)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reload the model with the zeros a freshly cleared pipe emits.
    task automatic sb_reset();
        q5.delete();
        q1.delete();
        q64.delete();
        repeat (4) q5.push_back('0);
        repeat (63) q64.push_back('0);
    endtask

    task automatic step(input logic [31:0] v);
        @(negedge clk);
        in5  = v;
        in1  = v[0] ^ v[3];
        in64 = {v, ~v, v ^ 32'hDEADBEEF, 32'hDEADBEEF};
        q5.push_back(in5);
        q1.push_back(in1);
        q64.push_back(in64);
        @(posedge clk);
        #1;
        chk("h5",  {96'd0, out5},  {96'd0, q5.pop_front()});
        chk("h1",  {127'd0, out1}, {127'd0, q1.pop_front()});
        chk("h64", out64, q64.pop_front());
    endtask

    initial begin
        // Asynchronous clear with no clock edge involved.
        #2;
        reset = 1'b0;
        in5   = 32'hFFFFFFFF;
        in64  = '1;
        in1   = 1'b1;
        #1;
        chk("rst_async5",  {96'd0, out5}, 128'd0);
        chk("rst_async64", out64, 128'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold5", {96'd0, out5}, 128'd0);
            chk("rst_hold1", {127'd0, out1}, 128'd0);
        end

        @(posedge clk);
        #5;
        reset = 1'b1;
        sb_reset();

        step(32'hFFFFFFFF);
        step(32'hAAAAFFFF);
        step(32'h0000FFFF);
        step(32'h0000AAAA);
        repeat (5) step(32'h0);

        for (int i = 1; i <= 100; i++) step(32'(i));

        for (int i = 0; i < 32; i++) step(32'h1 << i);

        step(32'h11111111);
        step(32'h22222222);
        step(32'h33333333);

        // Half-cycle reset pulse spanning one rising edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst5",  {96'd0, out5}, 128'd0);
        chk("mid_rst1",  {127'd0, out1}, 128'd0);
        chk("mid_rst64", out64, 128'd0);
        #9;
        chk("mid_edge5", {96'd0, out5}, 128'd0);
        #1;
        reset = 1'b1;
        sb_reset();

        step(32'h12345678);
        repeat (70) step(32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
